cos_job_sequencer: RTL and testbench
====================================

Name: cos_job_sequencer

Overview:
- Initiator side of the cosine accelerator's start/done handshake.
- Buffers incoming angle words in a small FIFO and launches one accelerator job per word.
- Captures each result into a one-entry output register and presents it downstream with a valid/ready handshake.
- Supervises each job with a timeout counter and flags a hung accelerator.

Parameters:
- X_W, 16, angle/input word width (fixed point, matches accelerator x input)
- RES_W, 16, result word width
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
- TIMEOUT, 255, max cycles from acc_start to acc_done before error

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input angle offered
- in_data  in  X_W  input angle
- in_ready  out  1  FIFO not full
- acc_start  out  1  one-cycle launch pulse to accelerator
- acc_x  out  X_W  angle presented to accelerator, stable from acc_start to acc_done
- acc_done  in  1  one-cycle pulse; acc_res valid this cycle
- acc_res  in  RES_W  accelerator result
- out_valid  out  1  result held
- out_data  out  RES_W  result
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE or FIFO non-empty
- err_timeout  out  1  sticky; set on timeout, cleared only by rst
- jobs_done  out  16  count of completed jobs, wraps at 65535->0

Behaviour:
- Reset values:
  - in_ready=1, acc_start=0, acc_x=0
  - out_valid=0, out_data=0
  - busy=0, err_timeout=0, jobs_done=0
  - FIFO empty, state IDLE
- Reset mid-job: abandons the job and flushes the FIFO. A later stray acc_done is ignored because state is IDLE.
- FIFO push: in_valid&in_ready.
  - in_ready = !full, registered-equivalent and without combinational dependence on in_valid.
  - Push and pop in the same cycle are allowed when full: no accept that cycle, because in_ready reflects pre-pop fullness.
- State machine:
  - IDLE:
    - If FIFO non-empty and out_valid=0 and err_timeout=0: pop head into acc_x, go LAUNCH.
    - The out_valid=0 condition keeps the single output slot from overflowing.
  - LAUNCH:
    - acc_start=1 for exactly this cycle; clear timeout counter; go WAIT.
  - WAIT:
    - Timeout counter increments each cycle.
    - On acc_done: out_data<=acc_res, out_valid<=1, jobs_done++, go IDLE.
    - Else if counter reaches TIMEOUT: err_timeout<=1, go IDLE. No result is produced and the job is dropped.
    - acc_done and timeout in the same cycle: acc_done wins.
- Output: out_valid clears on out_valid&out_ready.
  - Back-to-back throughput: the next launch can occur in the cycle after the output is consumed.
  - A new result never overwrites an unconsumed one.
- acc_done outside WAIT is ignored and has no effect on any output.
- Error halt: while err_timeout=1, no new jobs launch. The FIFO still accepts until full. A pending output can still drain.
- Minimum latency: push at cycle 0 → pop/IDLE cycle 1 → acc_start cycle 2 → earliest acc_done cycle 3 → out_valid high in cycle 4.
- Widths: jobs_done wraps modulo 2^16. The timeout counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package cos_acc_pkg:
  - state enum {IDLE, LAUNCH, WAIT}
  - default X_W/RES_W constants
  - TIMEOUT default
- Sub-module sync_fifo:
  - Parameters X_W, FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers carry an extra wrap bit for the full/empty distinction.
- The top level instantiates sync_fifo plus the FSM, output register and counters.

Test Plan:
- Single job: push x=16'h1000; acc model returns 16'h0F00 after 5 cycles → acc_start pulses once 2 cycles after push; out_data=16'h0F00 with out_valid; jobs_done=1.
- Full FIFO: out_ready=0, push 6 words with acc latency 3 → in_ready drops after 4 buffered (1 in flight, output slot holds result); out_ready=1 then yields results in order, jobs_done=6.
- Backpressure: hold out_ready=0 for 20 cycles with 2 queued → no second acc_start until the first result is consumed.
- Timeout: acc model never returns, TIMEOUT=255 → err_timeout=1 exactly 255 cycles after WAIT entry; no further acc_start; out_valid stays 0.
- Simultaneous acc_done and timeout at cycle 255 → result captured, err_timeout stays 0.
- Async reset asserted during WAIT → all outputs at reset values immediately; a later acc_done pulse produces no out_valid.

Source files
------------

// File: rtl/cos_acc_pkg.sv
// Shared types and defaults for the cosine accelerator job sequencer.
package cos_acc_pkg;

    localparam int X_W_DEF        = 16;
    localparam int RES_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    // Job sequencer states: wait for work, pulse start, wait for done.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding angle words until a job can be launched.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int X_W        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [X_W-1:0] din,
    output logic [X_W-1:0] dout,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [X_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    // Pushes into a full FIFO and pops from an empty one are dropped.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset flushes all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cos_job_sequencer.sv
// Initiator side of the cosine accelerator start/done handshake.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; in_ready depends only on FIFO fullness, never on in_valid,
// and out_valid stays high with out_data stable until out_ready is seen.
module cos_job_sequencer
    import cos_acc_pkg::*;
#(
    parameter int X_W        = X_W_DEF,
    parameter int RES_W      = RES_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [X_W-1:0]   in_data,
    output logic             in_ready,
    output logic             acc_start,
    output logic [X_W-1:0]   acc_x,
    input  logic             acc_done,
    input  logic [RES_W-1:0] acc_res,
    output logic             out_valid,
    output logic [RES_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             err_timeout,
    output logic [15:0]      jobs_done,
    output state_t           dbg_state
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc_start;
    logic [X_W-1:0]     r_acc_x;
    logic               r_out_valid;
    logic [RES_W-1:0]   r_out_data;
    logic               r_err;
    logic [15:0]        r_jobs;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [X_W-1:0]     w_head;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    // Launch only when the output slot is free so a result can never be lost.
    assign w_pop    = (r_state == IDLE) && !w_empty && !r_out_valid && !r_err;

    // Timeout counter saturates rather than wrapping.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    sync_fifo #(
        .X_W        (X_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Job FSM with output register, timeout supervision and job counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc_start <= 1'b0;
            r_acc_x     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            r_jobs      <= '0;
        end else begin
            r_acc_start <= 1'b0;
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_acc_x     <= w_head;
                        r_acc_start <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done pulse wins over a timeout landing in the same cycle.
                    if (acc_done) begin
                        r_out_data  <= acc_res;
                        r_out_valid <= 1'b1;
                        r_jobs      <= r_jobs + 16'd1;
                        r_state     <= IDLE;
                    end else if (w_cnt_inc >= TO_VAL) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign acc_start   = r_acc_start;
    assign acc_x       = r_acc_x;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign err_timeout = r_err;
    assign jobs_done   = r_jobs;
    assign busy        = (r_state != IDLE) || !w_empty;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cos_job_sequencer.sv
// Directed bench for cos_job_sequencer with an accelerator responder and a
// transaction-level reference model checked every cycle.
module tb_cos_job_sequencer;
    import cos_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        acc_start;
    logic [15:0] acc_x;
    logic        acc_done;
    logic [15:0] acc_res;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;
    logic [15:0] jobs_done;
    state_t      dbg_state;

    always #5 clk = ~clk;

    cos_job_sequencer #(
        .X_W(16), .RES_W(16), .FIFO_DEPTH(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .acc_start(acc_start), .acc_x(acc_x),
        .acc_done(acc_done), .acc_res(acc_res),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err_timeout(err_timeout), .jobs_done(jobs_done),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accelerator responder: the result is angle XOR 16'h1F00, returned
    // rsp_lat cycles after the start pulse; rsp_lat==0 means never answer.
    int          rsp_lat = 1;
    int          rsp_d;
    logic [15:0] rsp_x;

    initial begin
        acc_done = 1'b0;
        acc_res  = '0;
        forever begin
            @(negedge clk);
            if (acc_start && !rst && rsp_lat > 0) begin
                rsp_d = rsp_lat;
                rsp_x = acc_x;
                repeat (rsp_d) @(posedge clk);
                #1;
                acc_done = 1'b1;
                acc_res  = rsp_x ^ 16'h1F00;
                @(posedge clk);
                #1;
                acc_done = 1'b0;
            end
        end
    end

    // Reference model: queue of accepted angles, queue of expected results,
    // one job in flight with its start cycle, one output slot.
    int          cyc = 0;
    logic [15:0] angle_q[$];
    logic [15:0] exp_q[$];
    bit          pending = 1'b0;
    int          start_cyc = 0;
    logic [15:0] cur_x = '0;
    bit          slot_m = 1'b0;
    bit          err_m = 1'b0;
    int          jobs_m = 0;
    int          n_start = 0;
    int          n_out = 0;

    // Compare DUT against the model each cycle, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            angle_q.delete();
            exp_q.delete();
            pending = 1'b0;
            slot_m  = 1'b0;
            err_m   = 1'b0;
            jobs_m  = 0;
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, slot_m});
            check("err_timeout", {31'd0, err_timeout}, {31'd0, err_m});
            check("jobs_done", {16'd0, jobs_done}, {16'd0, jobs_m[15:0]});
            if (pending) check("acc_x_stable", {16'd0, acc_x}, {16'd0, cur_x});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
                else check("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                n_out++;
                slot_m = 1'b0;
            end
            if (acc_start) begin
                n_start++;
                check("start_allowed", {29'd0, pending, slot_m, err_m}, 32'd0);
                if (angle_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
                else check("acc_x", {16'd0, acc_x}, {16'd0, angle_q.pop_front()});
                pending   = 1'b1;
                start_cyc = cyc;
                cur_x     = acc_x;
            end else if (pending) begin
                if (acc_done) begin
                    exp_q.push_back(cur_x ^ 16'h1F00);
                    slot_m  = 1'b1;
                    jobs_m++;
                    pending = 1'b0;
                end else if (cyc - start_cyc == 255) begin
                    err_m   = 1'b1;
                    pending = 1'b0;
                end
            end
            if (in_valid && in_ready) angle_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] x);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (acc_start) found = 1'b1;
        end
        if (!found) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_outs(input string name, input int target);
        for (int i = 0; i < 2000 && n_out < target; i++) @(negedge clk);
        check(name, n_out, target);
    endtask

    initial begin
        int n;
        int s0;
        int o0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_acc_start", {31'd0, acc_start}, 32'd0);
        check("rst_acc_x", {16'd0, acc_x}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_jobs", {16'd0, jobs_done}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single job: start two cycles after push, result six cycles after start.
        rsp_lat = 5;
        s0 = n_start;
        in_valid = 1'b1; in_data = 16'h1000;
        @(negedge clk);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_no_start_p1", {31'd0, acc_start}, 32'd0);
        @(negedge clk);
        check("t1_start_p2", {31'd0, acc_start}, 32'd1);
        check("t1_acc_x", {16'd0, acc_x}, 32'h1000);
        n = 0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", n, 6);
        check("t1_out_data", {16'd0, out_data}, 32'h0F00);
        check("t1_jobs", {16'd0, jobs_done}, 32'd1);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_one_start", n_start - s0, 1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // Full FIFO: one job parked in the output slot plus four buffered words.
        do_reset();
        rsp_lat = 3;
        o0 = n_out;
        push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0400); push(16'h0500);
        repeat (10) tick();
        @(negedge clk);
        check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t2_slot_held", {31'd0, out_valid}, 32'd1);
        check("t2_jobs_1", {16'd0, jobs_done}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        tick();
        out_ready = 1'b1;
        push(16'h0600);
        wait_outs("t2_all_out", o0 + 6);
        tick();
        check("t2_jobs_6", {16'd0, jobs_done}, 32'd6);
        check("t2_drained", exp_q.size() + angle_q.size(), 0);
        out_ready = 1'b0;

        // Backpressure: second job waits for the first result to be consumed.
        do_reset();
        rsp_lat = 2;
        s0 = n_start;
        o0 = n_out;
        push(16'h0A00); push(16'h0B00);
        repeat (20) tick();
        check("t3_one_start", n_start - s0, 1);
        check("t3_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_outs("t3_both_out", o0 + 2);
        check("t3_two_starts", n_start - s0, 2);
        tick();

        // Timeout: no answer, error exactly 255 cycles after entering WAIT.
        do_reset();
        rsp_lat = 0;
        push(16'h2000);
        wait_start("t4_start_seen");
        n = 0;
        for (int i = 0; i < 300 && !err_timeout; i++) begin
            @(negedge clk);
            n++;
        end
        check("t4_err_delay", n, 256);
        tick();
        s0 = n_start;
        push(16'h3000);
        repeat (30) tick();
        check("t4_no_launch", n_start - s0, 0);
        check("t4_no_out", {31'd0, out_valid}, 32'd0);
        check("t4_in_ready", {31'd0, in_ready}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd1);
        check("t4_err_sticky", {31'd0, err_timeout}, 32'd1);

        // Done on the last allowed cycle beats the timeout.
        do_reset();
        out_ready = 1'b0;
        rsp_lat = 255;
        push(16'h1234);
        for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
        check("t5_out_valid", {31'd0, out_valid}, 32'd1);
        check("t5_out_data", {16'd0, out_data}, 32'h0D34);
        check("t5_err_clear", {31'd0, err_timeout}, 32'd0);
        check("t5_jobs", {16'd0, jobs_done}, 32'd1);
        tick();
        out_ready = 1'b1;
        tick();
        tick();

        // Async reset during WAIT; the stray done afterwards must be ignored.
        do_reset();
        rsp_lat = 10;
        push(16'h4000);
        wait_start("t6_start_seen");
        tick(); tick(); tick();
        s0 = n_start;
        rst = 1'b1;
        #1;
        check("t6_acc_start", {31'd0, acc_start}, 32'd0);
        check("t6_acc_x", {16'd0, acc_x}, 32'd0);
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_out_data", {16'd0, out_data}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_jobs", {16'd0, jobs_done}, 32'd0);
        check("t6_state", {30'd0, dbg_state}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (15) tick();
        check("t6_stray_done", {31'd0, out_valid}, 32'd0);
        check("t6_jobs_after", {16'd0, jobs_done}, 32'd0);
        check("t6_no_launch", n_start - s0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
